// File: rtl/lane_reorder_ctrl.sv
// ---------------------------------------------------------------------------
// lane_reorder_ctrl
//
// Receive-side lane reorder controller. Waits until every physical lane has
// alignment-marker lock, then walks the per-lane logical IDs (one physical
// lane per cycle) to build a logical->physical selector table. The table is
// checked for duplicate, out-of-range and missing IDs and, if clean, is loaded
// into the swap mux with a one-cycle done pulse. Any loss of lock restarts
// the whole sequence.
//
// Optional feature: define LANE_REORDER_CTRL_TIMEOUT_EN to enable a
// partial-lock timeout counter that pulses o_timeout every TIMEOUT_CYCLES
// cycles while some, but not all, lanes are locked. Without the macro
// o_timeout is tied low.
//
// Ports:
//   i_clock         single clock
//   i_reset_n       synchronous, active-low reset
//   i_enable        block enable; low freezes FSM, counters and outputs
//   i_am_lock       per-physical-lane AM lock, bit N_LANES-1 is phy lane 0
//   i_phy_ids       logical ID seen on each phy lane, phy 0 in the MSBs
//   o_lane_ids      selector table, logical 0 in the MSBs, each field a phy
//                   lane index
//   o_reorder_done  one-cycle pulse when o_lane_ids is updated
//   o_reorder_ok    table valid and all lanes locked
//   o_dup_error     sticky until next build: duplicate / out-of-range ID
//   o_missing_error sticky until next build: a logical ID was never seen
//   o_timeout       partial-lock timeout pulse (optional feature)
// ---------------------------------------------------------------------------
module lane_reorder_ctrl #(
  parameter int NB_DATA        = 66,
  parameter int N_LANES        = 20,
  parameter int NB_ID          = $clog2(N_LANES),
  parameter int NB_ID_BUS      = NB_ID * N_LANES,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic [N_LANES-1:0]   i_am_lock,
  input  logic [NB_ID_BUS-1:0] i_phy_ids,
  output logic [NB_ID_BUS-1:0] o_lane_ids,
  output logic                 o_reorder_done,
  output logic                 o_reorder_ok,
  output logic                 o_dup_error,
  output logic                 o_missing_error,
  output logic                 o_timeout
);

  // Reject configurations that cannot work at elaboration time.
  if (NB_DATA < 1 || TIMEOUT_CYCLES < 2 || NB_ID_BUS != NB_ID * N_LANES ||
      (1 << NB_ID) < N_LANES) begin : g_bad_cfg
    $error("lane_reorder_ctrl: inconsistent parameter set");
  end

  typedef enum logic [2:0] {
    WAIT_LOCK,
    BUILD,
    CHECK,
    DONE,
    LOCKED,
    ERROR
  } state_t;

  localparam logic [NB_ID-1:0] LAST_PTR = NB_ID'(N_LANES - 1);

  state_t               state_reg;
  logic [NB_ID-1:0]     phy_ptr_reg;
  logic [NB_ID-1:0]     scratch_reg [N_LANES];
  logic [N_LANES-1:0]   seen_reg;
  logic                 dup_reg;          // internal sticky flags, published in ERROR
  logic                 missing_reg;
  logic [NB_ID_BUS-1:0] lane_ids_reg;
  logic                 done_reg;
  logic                 ok_reg;
  logic                 dup_out_reg;
  logic                 missing_out_reg;

  logic [NB_ID-1:0]     phy_id [N_LANES];
  logic [NB_ID_BUS-1:0] scratch_packed;
  logic [NB_ID-1:0]     cur_id;
  logic                 all_locked;
  logic                 id_in_range;
  logic                 build_wr;

  // Unpack the ID bus (phy 0 in MSBs) and pack the scratch table
  // (logical 0 in MSBs) for the final copy.
  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      assign phy_id[gi] = i_phy_ids[(N_LANES-1-gi)*NB_ID +: NB_ID];
      assign scratch_packed[(N_LANES-1-gi)*NB_ID +: NB_ID] = scratch_reg[gi];
    end
  endgenerate

  assign all_locked  = &i_am_lock;
  assign cur_id      = phy_id[phy_ptr_reg];
  assign id_in_range = (32'(cur_id) < 32'(N_LANES));
  // A BUILD step claims a scratch slot only for a fresh, in-range ID.
  assign build_wr    = (state_reg == BUILD) && all_locked && id_in_range &&
                       !seen_reg[cur_id];

  // Scratch table: cleared while waiting for lock, one slot written per
  // BUILD cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_LANES; i++) scratch_reg[i] <= '0;
    end else if (i_enable) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (state_reg == WAIT_LOCK) begin
          scratch_reg[i] <= '0;
        end else if (build_wr && cur_id == NB_ID'(i)) begin
          scratch_reg[i] <= phy_ptr_reg;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_reg       <= WAIT_LOCK;
      phy_ptr_reg     <= '0;
      seen_reg        <= '0;
      dup_reg         <= 1'b0;
      missing_reg     <= 1'b0;
      lane_ids_reg    <= '0;
      done_reg        <= 1'b0;
      ok_reg          <= 1'b0;
      dup_out_reg     <= 1'b0;
      missing_out_reg <= 1'b0;
    end else if (i_enable) begin
      done_reg <= 1'b0;
      case (state_reg)
        WAIT_LOCK: begin
          ok_reg      <= 1'b0;
          phy_ptr_reg <= '0;
          seen_reg    <= '0;
          if (all_locked) begin
            // Error flags survive the lock loss and clear only here, as the
            // next build starts.
            dup_reg         <= 1'b0;
            missing_reg     <= 1'b0;
            dup_out_reg     <= 1'b0;
            missing_out_reg <= 1'b0;
            state_reg       <= BUILD;
          end
        end

        BUILD: begin
          if (!all_locked) begin
            state_reg <= WAIT_LOCK;
          end else begin
            if (build_wr) begin
              seen_reg[cur_id] <= 1'b1;
            end else begin
              dup_reg <= 1'b1;
            end
            if (phy_ptr_reg == LAST_PTR) begin
              state_reg <= CHECK;
            end else begin
              phy_ptr_reg <= phy_ptr_reg + NB_ID'(1);
            end
          end
        end

        CHECK: begin
          if (!all_locked) begin
            state_reg <= WAIT_LOCK;
          end else if (dup_reg) begin
            state_reg <= ERROR;
          end else if (!(&seen_reg)) begin
            missing_reg <= 1'b1;
            state_reg   <= ERROR;
          end else begin
            state_reg <= DONE;
          end
        end

        DONE: begin
          // Lock loss wins over the load: no pulse, table untouched.
          if (!all_locked) begin
            state_reg <= WAIT_LOCK;
          end else begin
            lane_ids_reg <= scratch_packed;
            done_reg     <= 1'b1;
            ok_reg       <= 1'b1;
            state_reg    <= LOCKED;
          end
        end

        LOCKED: begin
          if (!all_locked) begin
            ok_reg    <= 1'b0;
            state_reg <= WAIT_LOCK;
          end
        end

        ERROR: begin
          dup_out_reg     <= dup_reg;
          missing_out_reg <= missing_reg;
          if (!all_locked) begin
            state_reg <= WAIT_LOCK;
          end
        end

        default: begin
          state_reg <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign o_lane_ids      = lane_ids_reg;
  assign o_reorder_done  = done_reg;
  assign o_reorder_ok    = ok_reg;
  assign o_dup_error     = dup_out_reg;
  assign o_missing_error = missing_out_reg;

`ifdef LANE_REORDER_CTRL_TIMEOUT_EN
  localparam int NB_TO = $clog2(TIMEOUT_CYCLES);

  logic [NB_TO-1:0] to_cnt_reg;
  logic             timeout_reg;
  logic             partial_lock;

  assign partial_lock = (|i_am_lock) && !all_locked;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else if (i_enable) begin
      timeout_reg <= 1'b0;
      if (state_reg == WAIT_LOCK && partial_lock) begin
        if (to_cnt_reg == NB_TO'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_reg  <= '0;
          timeout_reg <= 1'b1;
        end else begin
          to_cnt_reg <= to_cnt_reg + NB_TO'(1);
        end
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

  assign o_timeout = timeout_reg;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lane_reorder_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for lane_reorder_ctrl. Directed steps plus randomized ID
// permutations; expected tables and error flags come from a reference model
// that derives them directly from the list of IDs on each physical lane.
// ---------------------------------------------------------------------------
module tb_lane_reorder_ctrl;

  localparam int N      = 20;
  localparam int NB_ID  = 5;
  localparam int NB_BUS = NB_ID * N;
  localparam int TO     = 16;

  logic              i_clock = 1'b0;
  logic              i_reset_n;
  logic              i_enable;
  logic [N-1:0]      i_am_lock;
  logic [NB_BUS-1:0] i_phy_ids;
  logic [NB_BUS-1:0] o_lane_ids;
  logic              o_reorder_done;
  logic              o_reorder_ok;
  logic              o_dup_error;
  logic              o_missing_error;
  logic              o_timeout;

  lane_reorder_ctrl #(
    .NB_DATA       (66),
    .N_LANES       (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock        (i_clock),
    .i_reset_n      (i_reset_n),
    .i_enable       (i_enable),
    .i_am_lock      (i_am_lock),
    .i_phy_ids      (i_phy_ids),
    .o_lane_ids     (o_lane_ids),
    .o_reorder_done (o_reorder_done),
    .o_reorder_ok   (o_reorder_ok),
    .o_dup_error    (o_dup_error),
    .o_missing_error(o_missing_error),
    .o_timeout      (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  int n_tests = 0;
  int n_fail  = 0;

  int                ids [N];     // logical ID carried on each phy lane
  logic [NB_BUS-1:0] cur_table;   // last table successfully loaded
  logic [NB_BUS-1:0] exp_table;
  bit                exp_dup;
  bit                exp_miss;

  task automatic check(input string tag, input logic [NB_BUS-1:0] obs,
                       input logic [NB_BUS-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive_ids();
    for (int p = 0; p < N; p++) i_phy_ids[(N-1-p)*NB_ID +: NB_ID] = NB_ID'(ids[p]);
  endtask

  task automatic set_identity();
    for (int p = 0; p < N; p++) ids[p] = p;
  endtask

  task automatic random_perm();
    int j, t;
    set_identity();
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = ids[i]; ids[i] = ids[j]; ids[j] = t;
    end
  endtask

  // Reference model: any out-of-range or repeated ID is a dup error; the
  // missing error applies only when there is no dup and some logical ID is
  // absent. Each logical entry holds the phy lane that carries that ID.
  task automatic model();
    int found;
    exp_dup   = 0;
    exp_miss  = 0;
    exp_table = '0;
    for (int p = 0; p < N; p++) begin
      if (ids[p] >= N) exp_dup = 1;
      for (int q = 0; q < p; q++) if (ids[q] == ids[p]) exp_dup = 1;
    end
    for (int l = 0; l < N; l++) begin
      found = -1;
      for (int p = 0; p < N; p++) if (ids[p] == l && found < 0) found = p;
      if (found < 0) begin
        if (!exp_dup) exp_miss = 1;
      end else begin
        exp_table[(N-1-l)*NB_ID +: NB_ID] = NB_ID'(found);
      end
    end
  endtask

  // Raise all locks from WAIT_LOCK and check the outcome 22 edges later.
  task automatic run_build(input string tag);
    model();
    drive_ids();
    i_am_lock = '1;
    tick();  // edge t: lock sampled, flags cleared
    check({tag, " flags_clear"}, {o_dup_error, o_missing_error}, 2'b00);
    repeat (20) tick();
    tick();  // t+21
    check({tag, " no_early_done"}, o_reorder_done, 1'b0);
    tick();  // t+22
    if (!exp_dup && !exp_miss) begin
      check({tag, " done"}, o_reorder_done, 1'b1);
      check({tag, " table"}, o_lane_ids, exp_table);
      check({tag, " ok"}, o_reorder_ok, 1'b1);
      check({tag, " flags"}, {o_dup_error, o_missing_error}, 2'b00);
      cur_table = exp_table;
    end else begin
      check({tag, " no_done"}, o_reorder_done, 1'b0);
      check({tag, " retained"}, o_lane_ids, cur_table);
      check({tag, " not_ok"}, o_reorder_ok, 1'b0);
      check({tag, " dup"}, o_dup_error, exp_dup);
      check({tag, " missing"}, o_missing_error, exp_miss);
    end
  endtask

  task automatic drop_lock();
    i_am_lock = '0;
    tick();
    check("drop_lock ok_low", o_reorder_ok, 1'b0);
    tick();
  endtask

  initial begin
    int a, b, mode;

    i_reset_n = 1'b0;
    i_enable  = 1'b1;
    i_am_lock = '0;
    i_phy_ids = '0;
    cur_table = '0;
    set_identity();

    // Reset values
    tick(); tick();
    check("reset table", o_lane_ids, '0);
    check("reset done", o_reorder_done, 1'b0);
    check("reset ok", o_reorder_ok, 1'b0);
    check("reset flags", {o_dup_error, o_missing_error, o_timeout}, 3'b000);
    i_reset_n = 1'b1;
    tick();

    // Identity mapping
    set_identity();
    run_build("identity");
    tick();
    check("identity pulse_one_cycle", o_reorder_done, 1'b0);
    check("identity ok_held", o_reorder_ok, 1'b1);
    drop_lock();

    // phy 9 -> logical 0, phy 2 -> logical 1
    set_identity();
    ids[9] = 0; ids[0] = 9;
    ids[2] = 1; ids[1] = 2;
    run_build("perm92");
    check("perm92 logical0", o_lane_ids[(N-1)*NB_ID +: NB_ID], 5'd9);
    check("perm92 logical1", o_lane_ids[(N-2)*NB_ID +: NB_ID], 5'd2);
    drop_lock();

    // phy 3 and phy 7 both report ID 5
    set_identity();
    ids[3] = 5; ids[7] = 5;
    run_build("dup35");
    repeat (3) tick();
    check("dup35 sticky", {o_dup_error, o_missing_error}, 2'b10);
    drop_lock();
    check("dup35 kept_in_wait", {o_dup_error, o_missing_error}, 2'b10);
    check("dup35 table_kept", o_lane_ids, cur_table);

    // Lock of phy 4 lost at BUILD cycle 10
    random_perm();
    drive_ids();
    i_am_lock = '1;
    tick();
    repeat (10) tick();
    i_am_lock[N-1-4] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      check("lockloss no_done", o_reorder_done, 1'b0);
    end
    check("lockloss table_kept", o_lane_ids, cur_table);
    i_am_lock = '0;
    tick();
    run_build("rebuild");
    drop_lock();

    // Lock lost while in DONE: no pulse, table unchanged
    do random_perm(); while (ids[0] == 9 && ids[2] == 1);
    model();
    drive_ids();
    i_am_lock = '1;
    tick();
    repeat (21) tick();
    i_am_lock[N-1-0] = 1'b0;
    tick();
    check("done_loss no_pulse", o_reorder_done, 1'b0);
    check("done_loss table_kept", o_lane_ids, cur_table);
    check("done_loss not_ok", o_reorder_ok, 1'b0);
    i_am_lock = '0;
    tick();

    // Enable low mid-BUILD stretches latency; enable low holds the pulse
    random_perm();
    model();
    drive_ids();
    i_am_lock = '1;
    tick();
    repeat (5) tick();
    i_enable = 1'b0;
    repeat (3) tick();
    i_enable = 1'b1;
    repeat (16) tick();
    check("enable no_early_done", o_reorder_done, 1'b0);
    tick();
    check("enable done", o_reorder_done, 1'b1);
    check("enable table", o_lane_ids, exp_table);
    cur_table = exp_table;
    i_enable = 1'b0;
    repeat (3) tick();
    check("enable pulse_held", o_reorder_done, 1'b1);
    i_enable = 1'b1;
    tick();
    check("enable pulse_ends", o_reorder_done, 1'b0);
    check("enable ok", o_reorder_ok, 1'b1);
    drop_lock();

    // Randomized permutations with optional dup / out-of-range injection
    for (int it = 0; it < 8; it++) begin
      random_perm();
      mode = $urandom_range(0, 2);
      a = $urandom_range(0, N - 1);
      if (mode == 1) begin
        b = (a + 1 + $urandom_range(0, N - 2)) % N;
        ids[a] = ids[b];
      end else if (mode == 2) begin
        ids[a] = $urandom_range(N, 31);
      end
      run_build($sformatf("rand%0d_m%0d", it, mode));
      drop_lock();
    end

    // Reset mid-BUILD
    random_perm();
    drive_ids();
    i_am_lock = '1;
    tick();
    repeat (5) tick();
    i_reset_n = 1'b0;
    tick();
    check("midreset table", o_lane_ids, '0);
    check("midreset outs", {o_reorder_done, o_reorder_ok, o_dup_error,
                            o_missing_error, o_timeout}, 5'b00000);
    i_reset_n = 1'b1;
    i_am_lock = '0;
    cur_table = '0;
    tick(); tick();

    // Partial lock: 19 of 20 lanes
    i_am_lock = '1;
    i_am_lock[N-1-7] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
`ifdef LANE_REORDER_CTRL_TIMEOUT_EN
      check($sformatf("timeout k%0d", k), o_timeout, (k % TO) == 0);
`else
      check($sformatf("timeout k%0d", k), o_timeout, 1'b0);
`endif
    end
    check("partial no_done", {o_reorder_done, o_reorder_ok}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_reorder_ctrl.md
# lane_reorder_ctrl

Controller that sequences the receive-side lane reorder datapath. It waits for alignment-marker lock on every physical lane, then walks the per-lane logical IDs one lane per cycle to build the selector table. It checks the table for duplicate, out-of-range and missing IDs, then loads the table into the swap mux with a single-cycle done pulse. It sits between the per-lane AM lock/ID extractors and the lane swap mux, and re-runs automatically whenever lock is lost.

## Interface
- `NB_DATA`, 66: block width; passed through only for consistency, no datapath use.
- `N_LANES`, 20: number of physical/logical lanes.
- `NB_ID`, `$clog2(N_LANES)`: width of one lane ID.
- `NB_ID_BUS`, `NB_ID*N_LANES`: width of the ID buses.
- `TIMEOUT_CYCLES`, 16384: partial-lock timeout limit; used only with `LANE_REORDER_CTRL_TIMEOUT_EN`.

Ports:
- `i_clock`  in  1  single clock.
- `i_reset_n`  in  1  synchronous, active-low reset.
- `i_enable`  in  1  block enable; when low, the FSM and counters hold.
- `i_am_lock`  in  N_LANES  per-physical-lane AM lock; bit N_LANES-1 is phy lane 0.
- `i_phy_ids`  in  NB_ID_BUS  logical ID received on each physical lane, packed `{phy_0,...,phy_N-1}` (phy 0 in MSBs).
- `o_lane_ids`  out  NB_ID_BUS  selector table, packed `{logical_0_sel,...,logical_N-1_sel}`; each field holds a physical lane index.
- `o_reorder_done`  out  1  one-cycle pulse when `o_lane_ids` is updated.
- `o_reorder_ok`  out  1  level: table valid and all lanes locked.
- `o_dup_error`  out  1  sticky until next BUILD: duplicate or out-of-range ID.
- `o_missing_error`  out  1  sticky until next BUILD: some logical ID never seen.
- `o_timeout`  out  1  one-cycle pulse; present only with `LANE_REORDER_CTRL_TIMEOUT_EN`.

## Operation
- FSM states: WAIT_LOCK, BUILD, CHECK, DONE, LOCKED, ERROR.
- **WAIT_LOCK:** when `&i_am_lock` is sampled → BUILD. On entry, clear the scratch table, the `seen[N_LANES-1:0]` vector and both error flags; reset `phy_ptr` to 0.
- **BUILD:** one physical lane per cycle.
  - Decode `id = i_phy_ids` field for `phy_ptr`.
  - If `id >= N_LANES`, or `seen[id]` is already set → set `o_dup_error`.
  - Otherwise write `scratch[id] = phy_ptr` and set `seen[id]`.
  - After `phy_ptr == N_LANES-1` → CHECK.
- **CHECK:**
  - `o_dup_error` set → ERROR.
  - Else `~&seen` → set `o_missing_error`, → ERROR.
  - Else → DONE.
- **DONE:** copy scratch to `o_lane_ids`, assert `o_reorder_done` for one cycle, → LOCKED.
- **LOCKED:** `o_reorder_ok` = 1. Any `i_am_lock` bit low → WAIT_LOCK, and `o_reorder_ok` drops the same cycle.
- **ERROR:** hold the error flags. Leave only on any lock bit low (→ WAIT_LOCK); there is no retry while fully locked.
- **Lock loss in BUILD/CHECK/DONE** (any bit low) → WAIT_LOCK. In DONE, lock loss has priority over the done pulse: no pulse, `o_lane_ids` unchanged.
- **`o_lane_ids` retention:** keeps its last good value through WAIT_LOCK and ERROR. It changes only in DONE.
- **Reset values:** `o_lane_ids` = 0, `o_reorder_done` = 0, `o_reorder_ok` = 0, both error flags 0, `o_timeout` = 0. FSM enters WAIT_LOCK.
- **Reset mid-BUILD:** aborts immediately; no done pulse.

## Timing
- All outputs are registered.
- Lock sampled all-high at edge t. BUILD occupies cycles t+1 … t+N_LANES, CHECK is t+N_LANES+1, and `o_reorder_done`/`o_reorder_ok` rise at edge t+N_LANES+2. For N_LANES=20 that is 22 cycles.
- `i_phy_ids` must be stable from t through the end of BUILD; the block does not snapshot it.
- `i_enable` low freezes state, `phy_ptr`, scratch and the timeout counter. Outputs hold, including a pending done pulse, which is extended until enable returns.
- Error flags appear at edge t+N_LANES+2, when the ERROR state is entered.

## Configuration
- **`LANE_REORDER_CTRL_TIMEOUT_EN` defined:**
  - A counter runs in WAIT_LOCK while `|i_am_lock && ~&i_am_lock`.
  - On reaching TIMEOUT_CYCLES-1 it pulses `o_timeout` and restarts from 0.
  - It clears whenever that condition is false or the FSM leaves WAIT_LOCK.
- **Not defined:** no counter; `o_timeout` is tied to 0.

## Test plan
- Reset, then all 20 locks high with identity IDs (phy p carries logical p) → done pulse 22 cycles later, `o_lane_ids` = {0,1,…,19}, ok = 1.
- phy 9 carries logical 0, phy 2 carries logical 1, others a valid permutation → `o_lane_ids` logical_0 field = 9, logical_1 field = 2; no errors.
- phy 3 and phy 7 both report ID 5 → `o_dup_error` = 1, `o_missing_error` = 0, no done pulse, `o_lane_ids` retains its prior value. Drop lock → WAIT_LOCK with flags still set; flags clear on the next BUILD.
- Lock bit of phy 4 drops at BUILD cycle 10 → FSM returns to WAIT_LOCK, no done pulse. Restore lock → full rebuild, done after 22 cycles.
- Lock drops the same cycle the FSM is in DONE → no pulse, `o_lane_ids` unchanged. Also: `i_reset_n` low mid-BUILD → all outputs at reset values on the next edge.
- With `LANE_REORDER_CTRL_TIMEOUT_EN` and TIMEOUT_CYCLES=16: 19 of 20 locks high → `o_timeout` pulses at cycles 16, 32, …. With the macro undefined, `o_timeout` stays 0.
